// File: rtl/vga_bank_reader.sv
// vga_bank_reader
//   Consumer side of the merge ping-pong pixel banks. A completed bank is
//   snapshotted into shadow registers, then serialised one pixel per
//   pixel_req toward the VGA output stage. This block owns the bank swap
//   (readVgaSelector) and reports underruns when VGA asks for a pixel while
//   no bank is loaded.
//
// Ports
//   clk                   system clock, rising edge
//   reset                 asynchronous, active-low reset
//   full_A, full_B        merge reports bank A / bank B completely written
//   R/G/B_inRegA          bank A channels, pixel k at [k*PIX_W +: PIX_W]
//   R/G/B_inRegB          bank B channels, same layout
//   pixel_req             VGA wants an active-video pixel this cycle
//   readVgaSelector       1: reader owns B, merge fills A; 0: the reverse
//   R_out, G_out, B_out   registered pixel colour
//   pixel_valid           R/G/B_out hold a real pixel this cycle
//   underrun              one-cycle pulse, request with no pixel available
//   underrun_count        saturating count of underrun pulses
module vga_bank_reader #(
   parameter int PIX_W        = 8,
   parameter int PIX_PER_BANK = 16,
   parameter int CNT_W        = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          full_A,
   input  logic                          full_B,
   input  logic [PIX_W*PIX_PER_BANK-1:0] R_inRegA,
   input  logic [PIX_W*PIX_PER_BANK-1:0] G_inRegA,
   input  logic [PIX_W*PIX_PER_BANK-1:0] B_inRegA,
   input  logic [PIX_W*PIX_PER_BANK-1:0] R_inRegB,
   input  logic [PIX_W*PIX_PER_BANK-1:0] G_inRegB,
   input  logic [PIX_W*PIX_PER_BANK-1:0] B_inRegB,
   input  logic                          pixel_req,
   output logic                          readVgaSelector,
   output logic [PIX_W-1:0]              R_out,
   output logic [PIX_W-1:0]              G_out,
   output logic [PIX_W-1:0]              B_out,
   output logic                          pixel_valid,
   output logic                          underrun,
   output logic [CNT_W-1:0]              underrun_count
);

   localparam int BANK_W = PIX_W * PIX_PER_BANK;
   // A single-pixel bank still needs a one-bit index register.
   localparam int IDX_W  = (PIX_PER_BANK > 1) ? $clog2(PIX_PER_BANK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX_PER_BANK - 1);

   typedef enum logic [1:0] {
      WAIT_FILL = 2'd0,
      LOAD      = 2'd1,
      STREAM    = 2'd2
   } state_t;

   state_t             state;
   logic               guard;
   logic [IDX_W-1:0]   pix_idx;
   logic [BANK_W-1:0]  shadow_r;
   logic [BANK_W-1:0]  shadow_g;
   logic [BANK_W-1:0]  shadow_b;

   logic               fill_full;
   logic               fill_ready;
   logic [BANK_W-1:0]  fill_r;
   logic [BANK_W-1:0]  fill_g;
   logic [BANK_W-1:0]  fill_b;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // The fill bank is whichever bank the reader does not currently own.
   // guard hides a full flag that merge has not yet dropped after a swap.
   always_comb begin
      fill_full  = readVgaSelector ? full_A   : full_B;
      fill_r     = readVgaSelector ? R_inRegA : R_inRegB;
      fill_g     = readVgaSelector ? G_inRegA : G_inRegB;
      fill_b     = readVgaSelector ? B_inRegA : B_inRegB;
      fill_ready = fill_full & ~guard;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= WAIT_FILL;
         readVgaSelector <= 1'b0;
         guard           <= 1'b0;
         pix_idx         <= '0;
         shadow_r        <= '0;
         shadow_g        <= '0;
         shadow_b        <= '0;
         R_out           <= '0;
         G_out           <= '0;
         B_out           <= '0;
         pixel_valid     <= 1'b0;
         underrun        <= 1'b0;
         underrun_count  <= '0;
      end else begin
         guard       <= 1'b0;
         pixel_valid <= 1'b0;
         underrun    <= 1'b0;

         // No bank loaded: a request is dropped and answered with black.
         if (pixel_req && (state != STREAM)) begin
            underrun       <= 1'b1;
            R_out          <= '0;
            G_out          <= '0;
            B_out          <= '0;
            underrun_count <= sat_inc(underrun_count);
         end

         case (state)
            WAIT_FILL: begin
               if (fill_ready) state <= LOAD;
            end

            LOAD: begin
               shadow_r        <= fill_r;
               shadow_g        <= fill_g;
               shadow_b        <= fill_b;
               readVgaSelector <= ~readVgaSelector;
               guard           <= 1'b1;
               pix_idx         <= '0;
               state           <= STREAM;
            end

            STREAM: begin
               if (pixel_req) begin
                  R_out       <= shadow_r[pix_idx*PIX_W +: PIX_W];
                  G_out       <= shadow_g[pix_idx*PIX_W +: PIX_W];
                  B_out       <= shadow_b[pix_idx*PIX_W +: PIX_W];
                  pixel_valid <= 1'b1;
                  if (pix_idx == LAST_IDX) begin
                     pix_idx <= '0;
                     // Seamless swap: next bank loaded on the same edge
                     // that emits the last pixel of the current one.
                     if (fill_ready) begin
                        shadow_r        <= fill_r;
                        shadow_g        <= fill_g;
                        shadow_b        <= fill_b;
                        readVgaSelector <= ~readVgaSelector;
                        guard           <= 1'b1;
                     end else begin
                        state <= WAIT_FILL;
                     end
                  end else begin
                     pix_idx <= pix_idx + 1'b1;
                  end
               end
            end

            default: state <= WAIT_FILL;
         endcase
      end
   end

endmodule
